kmp_match_pe: RTL and testbench

Parametrised KMP matching processing element for the parallel string-match engine.
- Accepts a string window, a pattern, the pattern's precomputed failure-function table and a candidate start range [start_idx, end_idx].
- Runs KMP at one compare step per cycle and reports the first match start index, or no-match, over a valid/ready result handshake.
- Several instances run side by side, each owning one start range of the same string.

---
 rtl/kmp_match_pe_pkg.sv | 17 +
 rtl/kmp_match_pe_char_sel.sv | 34 +++
 rtl/kmp_match_pe.sv | 178 +++++++++++++++++
 tb/tb_kmp_match_pe.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/kmp_match_pe_pkg.sv
// Shared definitions for the string-match engine: default sizes and FSM encodings.
package kmp_match_pe_pkg;

  localparam int DEF_MAX_STRING  = 32;
  localparam int DEF_MAX_PATTERN = 8;
  localparam int DEF_CHAR_W      = 8;
  localparam int DEF_STR_AW      = 6;
  localparam int DEF_PAT_AW      = 4;

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    PRE  = 4'b0010,
    COMP = 4'b0100,
    DONE = 4'b1000
  } kmp_state_t;

endpackage

// File: rtl/kmp_match_pe_char_sel.sv
// Combinational selector: picks str[i], pat[j] and ff[j-1] out of the flat job buses.
module kmp_char_sel
  import kmp_match_pe_pkg::*;
#(
  parameter int MAX_STRING  = DEF_MAX_STRING,
  parameter int MAX_PATTERN = DEF_MAX_PATTERN,
  parameter int CHAR_W      = DEF_CHAR_W,
  parameter int STR_AW      = DEF_STR_AW,
  parameter int PAT_AW      = DEF_PAT_AW
) (
  input  logic [MAX_STRING*CHAR_W-1:0]  str_vec,
  input  logic [MAX_PATTERN*CHAR_W-1:0] pat_vec,
  input  logic [MAX_PATTERN*PAT_AW-1:0] ff_vec,
  input  logic [STR_AW-1:0]             i,
  input  logic [PAT_AW-1:0]             j,
  output logic [CHAR_W-1:0]             str_ch,
  output logic [CHAR_W-1:0]             pat_ch,
  output logic [PAT_AW-1:0]             ff_prev
);

  // Out-of-range indices read as zero; the FSM never consumes them.
  always_comb begin
    str_ch  = '0;
    pat_ch  = '0;
    ff_prev = '0;
    for (int k = 0; k < MAX_STRING; k++)
      if (i == STR_AW'(k)) str_ch = str_vec[k*CHAR_W +: CHAR_W];
    for (int k = 0; k < MAX_PATTERN; k++) begin
      if (j == PAT_AW'(k))     pat_ch  = pat_vec[k*CHAR_W +: CHAR_W];
      if (j == PAT_AW'(k + 1)) ff_prev = ff_vec[k*PAT_AW +: PAT_AW];
    end
  end

endmodule

// File: rtl/kmp_match_pe.sv
// KMP matching processing element: one compare step per cycle over a start range.
// Optional MATCH_COUNT_EN: counts all matches in the range and adds match_cnt.
module kmp_match_pe
  import kmp_match_pe_pkg::*;
#(
  parameter int MAX_STRING  = DEF_MAX_STRING,
  parameter int MAX_PATTERN = DEF_MAX_PATTERN,
  parameter int CHAR_W      = DEF_CHAR_W,
  parameter int STR_AW      = DEF_STR_AW,
  parameter int PAT_AW      = DEF_PAT_AW
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [MAX_STRING*CHAR_W-1:0]  str_input,
  input  logic [STR_AW-1:0]             str_len,
  input  logic [MAX_PATTERN*CHAR_W-1:0] pat_input,
  input  logic [PAT_AW-1:0]             pat_len,
  input  logic [MAX_PATTERN*PAT_AW-1:0] ff_result,
  input  logic [STR_AW-1:0]             start_idx,
  input  logic [STR_AW-1:0]             end_idx,
  input  logic                          input_valid,
  output logic                          input_ready,
  output logic                          output_valid,
  input  logic                          out_ready,
`ifdef MATCH_COUNT_EN
  output logic [STR_AW-1:0]             match_cnt,
`endif
  output logic                          match,
  output logic [STR_AW-1:0]             match_idx
);

  kmp_state_t state, state_n;

  logic [MAX_STRING*CHAR_W-1:0]  str_r;
  logic [MAX_PATTERN*CHAR_W-1:0] pat_r;
  logic [MAX_PATTERN*PAT_AW-1:0] ff_r;
  logic [STR_AW-1:0]             str_len_r, start_r, end_r;
  logic [PAT_AW-1:0]             pat_len_r;

  logic [STR_AW-1:0] i, i_n;
  logic [PAT_AW-1:0] j, j_n;
  logic              match_n;
  logic [STR_AW-1:0] match_idx_n;
  logic [CHAR_W-1:0] str_ch, pat_ch;
  logic [PAT_AW-1:0] ff_prev;
  logic [STR_AW-1:0] cur_start;
  logic              job_bad;

`ifdef MATCH_COUNT_EN
  logic [STR_AW-1:0] match_cnt_n;
  logic [PAT_AW-1:0] ff_last;

  always_comb begin
    ff_last = '0;
    for (int k = 0; k < MAX_PATTERN; k++)
      if (pat_len_r == PAT_AW'(k + 1)) ff_last = ff_r[k*PAT_AW +: PAT_AW];
  end
`endif

  kmp_char_sel #(
    .MAX_STRING (MAX_STRING),
    .MAX_PATTERN(MAX_PATTERN),
    .CHAR_W     (CHAR_W),
    .STR_AW     (STR_AW),
    .PAT_AW     (PAT_AW)
  ) u_char_sel (
    .str_vec(str_r),
    .pat_vec(pat_r),
    .ff_vec (ff_r),
    .i      (i),
    .j      (j),
    .str_ch (str_ch),
    .pat_ch (pat_ch),
    .ff_prev(ff_prev)
  );

  assign cur_start    = i - STR_AW'(j);
  assign input_ready  = (state == IDLE);
  assign output_valid = (state == DONE);

  // The length check is one bit wider so start_idx+pat_len cannot wrap.
  assign job_bad = (pat_len_r == '0) ||
                   (pat_len_r > PAT_AW'(MAX_PATTERN)) ||
                   (start_r > end_r) ||
                   (({1'b0, start_r} + (STR_AW+1)'(pat_len_r)) > {1'b0, str_len_r});

  always_comb begin
    state_n     = state;
    i_n         = i;
    j_n         = j;
    match_n     = match;
    match_idx_n = match_idx;
`ifdef MATCH_COUNT_EN
    match_cnt_n = match_cnt;
`endif
    unique case (state)
      IDLE: if (input_valid) state_n = PRE;
      PRE: begin
        i_n         = start_r;
        j_n         = '0;
        match_n     = 1'b0;
        match_idx_n = '0;
`ifdef MATCH_COUNT_EN
        match_cnt_n = '0;
`endif
        state_n     = job_bad ? DONE : COMP;
      end
      COMP: begin
        if ((i >= str_len_r) || (cur_start > end_r)) begin
          state_n = DONE;
        end else if (str_ch == pat_ch) begin
          if (j == pat_len_r - PAT_AW'(1)) begin
`ifdef MATCH_COUNT_EN
            if (match_cnt == '0) match_idx_n = cur_start;
            match_n     = 1'b1;
            match_cnt_n = match_cnt + STR_AW'(1);
            j_n         = ff_last;
            i_n         = i + STR_AW'(1);
`else
            match_n     = 1'b1;
            match_idx_n = cur_start;
            state_n     = DONE;
`endif
          end else begin
            i_n = i + STR_AW'(1);
            j_n = j + PAT_AW'(1);
          end
        end else if (j != '0) begin
          j_n = ff_prev;
        end else begin
          i_n = i + STR_AW'(1);
        end
      end
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Job inputs are captured only on acceptance and held for the whole job.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      match     <= 1'b0;
      match_idx <= '0;
      str_r     <= '0;
      pat_r     <= '0;
      ff_r      <= '0;
      str_len_r <= '0;
      pat_len_r <= '0;
      start_r   <= '0;
      end_r     <= '0;
`ifdef MATCH_COUNT_EN
      match_cnt <= '0;
`endif
    end else begin
      state     <= state_n;
      i         <= i_n;
      j         <= j_n;
      match     <= match_n;
      match_idx <= match_idx_n;
`ifdef MATCH_COUNT_EN
      match_cnt <= match_cnt_n;
`endif
      if (state == IDLE && input_valid) begin
        str_r     <= str_input;
        pat_r     <= pat_input;
        ff_r      <= ff_result;
        str_len_r <= str_len;
        pat_len_r <= pat_len;
        start_r   <= start_idx;
        end_r     <= end_idx;
      end
    end
  end

endmodule

// File: tb/tb_kmp_match_pe.sv
// Directed bench for kmp_match_pe with hand-computed results; honours MATCH_COUNT_EN.
module tb_kmp_match_pe;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] str_input;
  logic [5:0]   str_len;
  logic [63:0]  pat_input;
  logic [3:0]   pat_len;
  logic [31:0]  ff_result;
  logic [5:0]   start_idx, end_idx;
  logic         input_valid, input_ready, output_valid, out_ready, match;
  logic [5:0]   match_idx;
`ifdef MATCH_COUNT_EN
  logic [5:0]   match_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;
  int lat;

  always #5 clk = ~clk;

  kmp_match_pe dut (
    .clk         (clk),
    .reset       (reset),
    .str_input   (str_input),
    .str_len     (str_len),
    .pat_input   (pat_input),
    .pat_len     (pat_len),
    .ff_result   (ff_result),
    .start_idx   (start_idx),
    .end_idx     (end_idx),
    .input_valid (input_valid),
    .input_ready (input_ready),
    .output_valid(output_valid),
    .out_ready   (out_ready),
`ifdef MATCH_COUNT_EN
    .match_cnt   (match_cnt),
`endif
    .match       (match),
    .match_idx   (match_idx)
  );

  function automatic logic [255:0] pack_str(input string s);
    logic [255:0] v = '0;
    for (int k = 0; k < s.len() && k < 32; k++) v[k*8 +: 8] = s[k];
    return v;
  endfunction

  function automatic logic [31:0] pack_ff(input int f0, input int f1, input int f2);
    logic [31:0] v = '0;
    v[3:0]  = 4'(f0);
    v[7:4]  = 4'(f1);
    v[11:8] = 4'(f2);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Presents a job for exactly one edge (the accept edge) while the DUT is idle.
  task automatic applyStimulus(input string s, input int slen, input string p, input int plen,
                               input logic [31:0] ff, input int st, input int en);
    str_input   = pack_str(s);
    str_len     = 6'(slen);
    pat_input   = 64'(pack_str(p));
    pat_len     = 4'(plen);
    ff_result   = ff;
    start_idx   = 6'(st);
    end_idx     = 6'(en);
    input_valid = 1'b1;
    tick();
    input_valid = 1'b0;
  endtask

  // Edges after the accept edge until output_valid is seen; bounded.
  task automatic waitResult(input string tag, output int edges);
    edges = 0;
    while (!output_valid && edges < 200) begin
      tick();
      edges++;
    end
    checkOutput({tag, "_valid"}, 32'(output_valid), 32'd1);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, "_valid_clr"}, 32'(output_valid), 32'd0);
    checkOutput({tag, "_ready"}, 32'(input_ready), 32'd1);
  endtask

  initial begin
    reset       = 1'b1;
    input_valid = 1'b0;
    out_ready   = 1'b0;
    str_input   = '0;
    str_len     = '0;
    pat_input   = '0;
    pat_len     = '0;
    ff_result   = '0;
    start_idx   = '0;
    end_idx     = '0;
    tick();
    tick();
    reset = 1'b0;
    $display("[TB] reset released");
    checkOutput("rst_ready", 32'(input_ready), 32'd1);
    checkOutput("rst_valid", 32'(output_valid), 32'd0);
    checkOutput("rst_match", 32'(match), 32'd0);
    checkOutput("rst_idx", 32'(match_idx), 32'd0);

    applyStimulus("ABCABD", 6, "ABD", 3, pack_ff(0, 0, 0), 0, 5);
    waitResult("abd", lat);
    checkOutput("abd_match", 32'(match), 32'd1);
    checkOutput("abd_idx", 32'(match_idx), 32'd3);
    consume("abd");

    // 1 PRE edge + 7 compare steps before DONE is visible
    applyStimulus("AAAAB", 5, "AAB", 3, pack_ff(0, 1, 0), 0, 4);
    waitResult("aab", lat);
    checkOutput("aab_latency", 32'(lat), 32'd8);
    checkOutput("aab_match", 32'(match), 32'd1);
    checkOutput("aab_idx", 32'(match_idx), 32'd2);
    consume("aab");

    applyStimulus("ABCD", 4, "XY", 2, pack_ff(0, 0, 0), 0, 3);
    waitResult("xy", lat);
    checkOutput("xy_match", 32'(match), 32'd0);
    checkOutput("xy_idx", 32'(match_idx), 32'd0);
    consume("xy");

    applyStimulus("ABCD", 4, "XY", 0, pack_ff(0, 0, 0), 0, 3);
    waitResult("plen0", lat);
    checkOutput("plen0_latency", 32'(lat), 32'd1);
    checkOutput("plen0_match", 32'(match), 32'd0);
    consume("plen0");

    applyStimulus("ABCDEFGHIJ", 10, "AB", 9, pack_ff(0, 0, 0), 0, 5);
    waitResult("plenbig", lat);
    checkOutput("plenbig_latency", 32'(lat), 32'd1);
    checkOutput("plenbig_match", 32'(match), 32'd0);
    consume("plenbig");

    applyStimulus("ABAB", 4, "AB", 2, pack_ff(0, 0, 0), 1, 3);
    waitResult("abab13", lat);
    checkOutput("abab13_match", 32'(match), 32'd1);
    checkOutput("abab13_idx", 32'(match_idx), 32'd2);
    consume("abab13");

    applyStimulus("ABAB", 4, "AB", 2, pack_ff(0, 0, 0), 3, 3);
    waitResult("abab33", lat);
    checkOutput("abab33_latency", 32'(lat), 32'd1);
    checkOutput("abab33_match", 32'(match), 32'd0);
    consume("abab33");

    // Start 1 fails, next candidate start 2 lies beyond end_idx
    applyStimulus("ABAB", 4, "AB", 2, pack_ff(0, 0, 0), 1, 1);
    waitResult("abab11", lat);
    checkOutput("abab11_match", 32'(match), 32'd0);
    checkOutput("abab11_idx", 32'(match_idx), 32'd0);
    consume("abab11");

    applyStimulus("ABCABD", 6, "ABD", 3, pack_ff(0, 0, 0), 0, 5);
    waitResult("stall", lat);
    input_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput("stall_valid", 32'(output_valid), 32'd1);
      checkOutput("stall_match", 32'(match), 32'd1);
      checkOutput("stall_idx", 32'(match_idx), 32'd3);
      checkOutput("stall_ready", 32'(input_ready), 32'd0);
    end
    input_valid = 1'b0;
    consume("stall");

    applyStimulus("ABCDEFGHIJKLMNOP", 16, "XY", 2, pack_ff(0, 0, 0), 0, 14);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("abort_ready", 32'(input_ready), 32'd1);
    checkOutput("abort_valid", 32'(output_valid), 32'd0);
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (output_valid) lat++;
    end
    checkOutput("abort_no_result", 32'(lat), 32'd0);

    applyStimulus("AAAA", 4, "AA", 2, pack_ff(0, 1, 0), 0, 3);
    waitResult("aaaa", lat);
    checkOutput("aaaa_match", 32'(match), 32'd1);
    checkOutput("aaaa_idx", 32'(match_idx), 32'd0);
`ifdef MATCH_COUNT_EN
    checkOutput("aaaa_cnt", 32'(match_cnt), 32'd3);
`endif
    consume("aaaa");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
